// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared definitions for the programmable counters and the
//               seven-segment display path: FSM state encoding, count
//               ceiling, BCD digit width and a binary-to-BCD helper.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int MAX_COUNT = 99;
  localparam int BCD_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Split a value in 0..99 into its two decimal digits.
  function automatic bcd2_t bin_to_bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] o;
    bcd2_t      r;
    t      = v / 7'd10;
    o      = v - (t * 7'd10);
    r.tens = t[BCD_W-1:0];
    r.ones = o[BCD_W-1:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_down.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_down
// Description : One decade (0..9) down-counter digit with parallel load,
//               enable, borrow-in and combinational borrow-out so digits
//               can be chained.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_down
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_borrow_in,
  output logic [BCD_W-1:0] o_q,
  output logic             o_borrow_out
);

  logic [BCD_W-1:0] r_q;

  // Digit register: load wins, otherwise step down with 0 wrapping to 9.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en && i_borrow_in) begin
      r_q <= (r_q == '0) ? BCD_W'(9) : r_q - BCD_W'(1);
    end
  end

  assign o_q          = r_q;
  assign o_borrow_out = i_borrow_in & (r_q == '0);

endmodule
`default_nettype wire

// File: rtl/prog_countdown_7b.sv
`default_nettype none
// ============================================================================
// Module      : prog_countdown_7b
// Description : Programmable 7-bit countdown timer with preset register,
//               clamp to MAX_COUNT, pause/restart control, one-cycle done
//               pulse and a two-digit BCD mirror of the binary count.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_countdown_7b
  import counter_pkg::*;
#(
  parameter int WIDTH     = 7,
  parameter int MAX_COUNT = counter_pkg::MAX_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  output logic [WIDTH-1:0] count_out,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             running,
  output logic             expired,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_preset;
  logic             r_running;
  logic             r_expired;
  logic             r_done;

  logic [WIDTH-1:0] w_clamped;
  logic             w_dec;
  logic             w_restart;
  logic             w_dig_load;
  logic [WIDTH-1:0] w_dig_val;
  bcd2_t            w_bcd;
  logic             w_ones_borrow;

  assign w_clamped = (load_value > WIDTH'(MAX_COUNT)) ? WIDTH'(MAX_COUNT) : load_value;

  // A decrement happens only in RUN on an unpaused tick; start in RUN is a
  // no-op, so it does not block the tick.
  assign w_dec = (r_state == ST_RUN) & ~load & ~pause & tick & (r_count != '0);

  // Restart from DONE reloads the digits from the preset register.
  assign w_restart  = ~load & start & (r_state == ST_DONE);
  assign w_dig_load = load | w_restart;
  assign w_dig_val  = load ? w_clamped : r_preset;
  assign w_bcd      = bin_to_bcd(7'(w_dig_val));

  bcd_digit_down u_ones (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_dig_load),
    .i_load_val   (w_bcd.ones),
    .i_en         (w_dec),
    .i_borrow_in  (1'b1),
    .o_q          (ones),
    .o_borrow_out (w_ones_borrow)
  );

  bcd_digit_down u_tens (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_dig_load),
    .i_load_val   (w_bcd.tens),
    .i_en         (w_dec),
    .i_borrow_in  (w_ones_borrow),
    .o_q          (tens),
    .o_borrow_out ()
  );

  // Control FSM with preset register, binary count and registered status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_preset  <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_preset  <= w_clamped;
        r_count   <= w_clamped;
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (r_count != '0) begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
              end else begin
                r_state   <= ST_DONE;
                r_expired <= 1'b1;
                r_done    <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end else if (tick) begin
              if (r_count == WIDTH'(1)) begin
                r_count   <= '0;
                r_state   <= ST_DONE;
                r_running <= 1'b0;
                r_expired <= 1'b1;
                r_done    <= 1'b1;
              end else if (r_count > WIDTH'(1)) begin
                r_count <= r_count - WIDTH'(1);
              end
            end
          end
          ST_PAUSED: begin
            // The tick coinciding with the resume cycle is dropped.
            if (!pause) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (start) begin
              r_count <= r_preset;
              if (r_preset != '0) begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
                r_expired <= 1'b0;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_expired <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_out = r_count;
  assign running   = r_running;
  assign expired   = r_expired;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_countdown_7b.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_countdown_7b
// Description : Directed scoreboard bench for prog_countdown_7b. The driver
//               queues the expected outputs for each checked cycle; the
//               monitor pops and compares after each clock edge or
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_countdown_7b;

  logic       clk;
  logic       reset;
  logic [6:0] load_value;
  logic       load, start, pause, tick;
  logic [6:0] count_out;
  logic [3:0] tens, ones;
  logic       running, expired, done;

  typedef struct {
    string name;
    int    c;
    bit    r;
    bit    e;
    bit    d;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  prog_countdown_7b dut (
    .clk        (clk),
    .reset      (reset),
    .load_value (load_value),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .count_out  (count_out),
    .tens       (tens),
    .ones       (ones),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation is consumed per clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (count_out !== 7'(e.c) || tens !== 4'(e.c / 10) || ones !== 4'(e.c % 10) ||
            running !== e.r || expired !== e.e || done !== e.d) begin
          n_fail++;
          $display("FAIL %s: got cnt=%0d tens=%0d ones=%0d run=%0b exp=%0b done=%0b, want cnt=%0d tens=%0d ones=%0d run=%0b exp=%0b done=%0b",
                   e.name, count_out, tens, ones, running, expired, done,
                   e.c, e.c / 10, e.c % 10, e.r, e.e, e.d);
        end
      end
    end
  end

  // Drive one cycle of inputs; optionally queue the expected post-edge outputs.
  task automatic cyc(input string nm, input bit ld, input int lv, input bit st,
                     input bit pa, input bit tk, input bit chk,
                     input int c, input bit r, input bit e, input bit d);
    exp_t x;
    @(negedge clk);
    load       = ld;
    load_value = 7'(lv);
    start      = st;
    pause      = pa;
    tick       = tk;
    @(posedge clk);
    if (chk) begin
      x.name = nm; x.c = c; x.r = r; x.e = e; x.d = d;
      q.push_back(x);
    end
  endtask

  task automatic async_reset(input string nm);
    exp_t x;
    x.name = nm; x.c = 0; x.r = 0; x.e = 0; x.d = 0;
    q.push_back(x);
    reset = 1'b0;
    #3;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; load = 0; load_value = 0; start = 0; pause = 0; tick = 0;
    #2;
    async_reset("reset_state");

    // Load 5, count to done.
    cyc("load5",      1, 5,   0, 0, 0, 1, 5, 0, 0, 0);
    cyc("start5",     0, 0,   1, 0, 0, 1, 5, 1, 0, 0);
    cyc("t5_4",       0, 0,   0, 0, 1, 1, 4, 1, 0, 0);
    cyc("t5_3",       0, 0,   0, 0, 1, 1, 3, 1, 0, 0);
    cyc("t5_2",       0, 0,   0, 0, 1, 1, 2, 1, 0, 0);
    cyc("t5_1",       0, 0,   0, 0, 1, 1, 1, 1, 0, 0);
    cyc("t5_done",    0, 0,   0, 0, 1, 1, 0, 0, 1, 1);
    cyc("done_1cyc",  0, 0,   0, 0, 0, 1, 0, 0, 1, 0);

    // Clamp.
    cyc("load120",    1, 120, 0, 0, 0, 1, 99, 0, 0, 0);
    cyc("start99",    0, 0,   1, 0, 0, 1, 99, 1, 0, 0);
    cyc("t99_98",     0, 0,   0, 0, 1, 1, 98, 1, 0, 0);

    // Borrow and pause.
    cyc("load10",     1, 10,  0, 0, 0, 1, 10, 0, 0, 0);
    cyc("start10",    0, 0,   1, 0, 0, 1, 10, 1, 0, 0);
    cyc("borrow9",    0, 0,   0, 0, 1, 1, 9, 1, 0, 0);
    cyc("pause_a",    0, 0,   0, 1, 1, 1, 9, 0, 0, 0);
    cyc("pause_b",    0, 0,   0, 1, 1, 1, 9, 0, 0, 0);
    cyc("pause_st",   0, 0,   1, 1, 1, 1, 9, 0, 0, 0);
    cyc("resume_tk",  0, 0,   0, 0, 1, 1, 9, 1, 0, 0);
    cyc("after_res",  0, 0,   0, 0, 1, 1, 8, 1, 0, 0);

    // Zero load.
    cyc("load0",      1, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    cyc("start0",     0, 0,   1, 0, 0, 1, 0, 0, 1, 1);
    cyc("zero_tk_a",  0, 0,   0, 0, 1, 1, 0, 0, 1, 0);
    cyc("zero_tk_b",  0, 0,   0, 0, 1, 1, 0, 0, 1, 0);
    cyc("restart0",   0, 0,   1, 0, 0, 1, 0, 0, 1, 1);

    // Restart from DONE.
    cyc("load3",      1, 3,   0, 0, 0, 1, 3, 0, 0, 0);
    cyc("start3",     0, 0,   1, 0, 0, 1, 3, 1, 0, 0);
    cyc("t3_2",       0, 0,   0, 0, 1, 1, 2, 1, 0, 0);
    cyc("t3_1",       0, 0,   0, 0, 1, 1, 1, 1, 0, 0);
    cyc("t3_done",    0, 0,   0, 0, 1, 1, 0, 0, 1, 1);
    cyc("restart3",   0, 0,   1, 0, 0, 1, 3, 1, 0, 0);
    cyc("r3_2",       0, 0,   0, 0, 1, 1, 2, 1, 0, 0);
    cyc("r3_1",       0, 0,   0, 0, 1, 1, 1, 1, 0, 0);
    cyc("r3_done",    0, 0,   0, 0, 1, 1, 0, 0, 1, 1);

    // Mid-count asynchronous reset, then load beats start.
    cyc("load50",     1, 50,  0, 0, 0, 1, 50, 0, 0, 0);
    cyc("start50",    0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc("t50", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("t50_43",     0, 0,   0, 0, 1, 1, 43, 1, 0, 0);
    #3;
    async_reset("async_rst");
    cyc("load_win",   1, 20,  1, 0, 0, 1, 20, 0, 0, 0);
    cyc("idle_tick",  0, 0,   0, 0, 1, 1, 20, 0, 0, 0);
    cyc("idle_quiet", 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_countdown_7b.md
# prog_countdown_7b

Programmable 7-bit down-counter (countdown timer), the counterpart of the team's programmable up-counter. It loads a preset (0–99), counts down by one on each `tick` strobe while running, and stops at zero with a one-cycle `done` pulse. It drives the same two-digit seven-segment display path, so it provides both binary and BCD count outputs. Restart reloads the last preset without a new load.

## Interface
- `WIDTH`, 7, count width in bits.
- `MAX_COUNT`, 99, ceiling for loaded values. Loads above it clamp to it.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Low forces the reset state immediately.
- `load_value` in 7: preset value, sampled when `load`=1.
- `load` in 1: load preset; highest priority after reset.
- `start` in 1: begin or restart the countdown.
- `pause` in 1: level; while high in RUN, ticks are ignored.
- `tick` in 1: one-cycle count-enable strobe (prescaled time base).
- `count_out` out 7: current binary count.
- `tens`, `ones` out 4 each: BCD digits of `count_out`.
- `running` out 1: high in RUN only.
- `expired` out 1: high in DONE.
- `done` out 1: one-cycle pulse when the count reaches 0 from RUN, or on a start at 0.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset values: state IDLE, `count_out`=0, `tens`=0, `ones`=0, preset register=0, `running`=0, `expired`=0, `done`=0.
- Priority per cycle: `load` > `start` > `pause` > `tick`.
- `load`, any state:
  - preset register and count ← min(`load_value`, `MAX_COUNT`).
  - Next state IDLE; `done` not asserted.
- IDLE + `start`:
  - count > 0 → RUN.
  - count = 0 → DONE with `done` pulse.
- RUN:
  - `pause`=1 → PAUSED; `tick` ignored that cycle.
  - Else on `tick` with count > 1: decrement.
  - On `tick` with count = 1: count ← 0, → DONE, `done`=1 in the same registered cycle.
- PAUSED:
  - `pause`=0 → RUN; a `tick` in that same cycle is ignored.
  - `start` while paused has no effect.
- DONE:
  - Count holds 0; `expired`=1.
  - `start` → count ← preset register. Preset > 0 → RUN; preset = 0 → `done` pulses again, stays DONE.
- `start` while in RUN: no effect (no restart mid-count).
- BCD digits:
  - On decrement: `ones` 0 borrows to 9 and `tens` decrements.
  - On load or restart: digits are computed from the loaded value.
  - Invariant: `tens`×10+`ones` = `count_out` at all times.
- Count never underflows below 0 and never exceeds `MAX_COUNT`.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Load latency: `count_out`, `tens`, `ones` and state update on the edge that samples `load`.
- Tick latency: one decrement per `tick`, visible on the next edge.
- `done` is high for exactly one cycle, coincident with the first cycle `count_out`=0 in DONE.
- `reset` low mid-count: outputs go to reset values asynchronously. First valid action is on the first rising edge after release.
- `tick` held high decrements every cycle; no edge detection is performed.

## Structure
- Shared package/include `counter_pkg`:
  - state encodings IDLE/RUN/PAUSED/DONE (2 bits)
  - `MAX_COUNT` = 99
  - BCD width constant, shared with the up-counter and the display decoder.
- One sub-module, `bcd_digit_down`: a 4-bit decade down-counter with load, enable, borrow-in and borrow-out. Instantiated twice (ones, tens).
- Top level holds the FSM, preset register, clamp logic and binary count.

## Test plan
- Reset then load 5, start, 5 ticks:
  - `count_out` 5→4→3→2→1→0
  - `done` pulses on the fifth tick edge; `expired`=1; `running`=0.
- Load 120:
  - `count_out`=99, `tens`=9, `ones`=9.
  - Start, one tick → 98, `tens`=9, `ones`=8.
- Load 10, start, one tick:
  - `count_out`=9, `tens`=0, `ones`=9 (borrow).
  - `pause` for 3 ticks → stays 9, state PAUSED.
  - Release plus tick in the same cycle → stays 9; next tick → 8.
- Load 0, start → `done` pulse in that cycle, DONE; further ticks → count stays 0.
- Load 3, run to DONE, assert `start` → count=3, RUN; 3 ticks → `done` again.
- Load 50, start, 7 ticks (count 43), then:
  - assert `reset` low asynchronously mid-cycle → all outputs 0, IDLE immediately.
  - `load` + `start` asserted together → loads, stays IDLE (load wins).
